// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle core: opcodes, funct codes, error codes, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int IW = 19;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_ADDI  = 5'd1;
    localparam logic [4:0] OP_LW    = 5'd2;
    localparam logic [4:0] OP_SW    = 5'd3;
    localparam logic [4:0] OP_BEQ   = 5'd4;
    localparam logic [4:0] OP_BNE   = 5'd5;
    localparam logic [4:0] OP_JMP   = 5'd6;
    localparam logic [4:0] OP_CALL  = 5'd7;
    localparam logic [4:0] OP_RET   = 5'd8;
    localparam logic [4:0] OP_HALT  = 5'd31;

    localparam logic [4:0] FN_ADD = 5'd0;
    localparam logic [4:0] FN_SUB = 5'd1;
    localparam logic [4:0] FN_AND = 5'd2;
    localparam logic [4:0] FN_OR  = 5'd3;
    localparam logic [4:0] FN_XOR = 5'd4;
    localparam logic [4:0] FN_SLT = 5'd5;
    localparam logic [4:0] FN_SLL = 5'd6;
    localparam logic [4:0] FN_SRL = 5'd7;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_UNF     = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // True for every executable opcode; HALT is handled separately by the decoder.
    function automatic logic op_legal(input logic [4:0] op, input logic [4:0] funct);
        logic ok;
        ok = 1'b0;
        if (op == OP_RTYPE) begin
            ok = (funct <= FN_SRL);
        end else if (op <= OP_RET) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO, DEPTH entries of W bits; o_top shows the most recent push.
// Latency: push/pop take effect on the next rising edge; o_top is combinational.
// Backpressure: push when full and pop when empty are ignored; caller checks o_full/o_empty.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]   r_cnt;
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] w_top_idx;

    assign w_top_idx = r_cnt[PW-1:0] - PW'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_full    = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);

    // Occupancy count and entry storage; a push writes at the current count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[r_cnt[PW-1:0]] <= i_dat;
            r_cnt                <= r_cnt + (PW+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle 19-bit-ISA core with req/ack instruction and data ports; optional perf counters via CPU_MC_PERF_CNT_EN.
// Latency: branch/jump 3, ALU/SW 4, LW 5 cycles with zero-wait memories; each wait state adds one.
// Backpressure: FETCH and MEM hold their request and operands until ack; ack without a request is ignored.
module cpu_mc_core
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 8,
    parameter int DADDR_W     = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [IW-1:0]      imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic [1:0]         err,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
);
    state_t            r_state, w_state_nxt;
    logic [1:0]        r_err, w_err_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [IW-1:0]     r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_alu, r_mdr;
    logic [DATA_W-1:0] r_rf [8];

    logic [4:0]        w_op, w_funct;
    logic [2:0]        w_rs, w_rt, w_rd, w_dest;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_imm_ext, w_opb, w_alu, w_wb_dat;
    logic [PC_W-1:0]   w_imm_pc, w_pc_inc, w_stk_top;
    logic              w_push, w_pop, w_stk_full, w_stk_empty, w_retire;

    assign w_op     = r_ir[18:14];
    assign w_rs     = r_ir[13:11];
    assign w_rt     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_funct  = r_ir[4:0];
    assign w_imm    = r_ir[7:0];
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_dat = (w_op == OP_LW) ? r_mdr : r_alu;

    // Fetch request is masked by reset so it falls the moment reset asserts.
    assign imem_req   = (r_state == S_FETCH) && reset;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign dmem_addr  = r_alu[DADDR_W-1:0];
    assign dmem_wdata = r_b;
    assign pc         = r_pc;
    assign halted     = (r_state == S_HALT);
    assign err        = r_err;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    // Zero-extend the 8-bit immediate to data and PC widths.
    always_comb begin
        w_imm_ext      = '0;
        w_imm_ext[7:0] = w_imm;
        w_imm_pc       = '0;
        w_imm_pc[7:0]  = w_imm;
    end

    // ALU: R-type uses B and funct; ADDI/LW/SW add the immediate to A.
    always_comb begin
        w_opb = (w_op == OP_RTYPE) ? r_b : w_imm_ext;
        w_alu = r_a + w_opb;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                FN_SUB:  w_alu = r_a - r_b;
                FN_AND:  w_alu = r_a & r_b;
                FN_OR:   w_alu = r_a | r_b;
                FN_XOR:  w_alu = r_a ^ r_b;
                FN_SLT:  w_alu = ($signed(r_a) < $signed(r_b)) ? DATA_W'(1) : '0;
                FN_SLL:  w_alu = r_a << r_b[4:0];
                FN_SRL:  w_alu = r_a >> r_b[4:0];
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    // Next state, error code, PC and stack control.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_op == OP_HALT) begin
                    w_state_nxt = S_HALT;
                end else if (!op_legal(w_op, w_funct)) begin
                    w_state_nxt = S_HALT;
                    w_err_nxt   = ERR_ILLEGAL;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
                case (w_op)
                    OP_RTYPE, OP_ADDI: begin
                        w_state_nxt = S_WB;
                        w_retire    = 1'b0;
                    end
                    OP_LW, OP_SW: begin
                        w_state_nxt = S_MEM;
                        w_retire    = 1'b0;
                    end
                    OP_BEQ:  if (r_a == r_b) w_pc_nxt = w_imm_pc;
                    OP_BNE:  if (r_a != r_b) w_pc_nxt = w_imm_pc;
                    OP_JMP:  w_pc_nxt = w_imm_pc;
                    OP_CALL: begin
                        if (w_stk_full) begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_HALT;
                            w_err_nxt   = ERR_OVF;
                            w_retire    = 1'b0;
                        end else begin
                            w_push   = 1'b1;
                            w_pc_nxt = w_imm_pc;
                        end
                    end
                    OP_RET: begin
                        if (w_stk_empty) begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_HALT;
                            w_err_nxt   = ERR_UNF;
                            w_retire    = 1'b0;
                        end else begin
                            w_pop    = 1'b1;
                            w_pc_nxt = w_stk_top;
                        end
                    end
                    default: begin
                        w_pc_nxt    = r_pc;
                        w_state_nxt = S_HALT;
                        w_err_nxt   = ERR_ILLEGAL;
                        w_retire    = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (w_op == OP_LW) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    // FSM state, error code and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_err   <= ERR_NONE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Datapath latches: IR on fetch ack, operands in decode, ALU result in exec, load data in mem.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_alu <= '0;
            r_mdr <= '0;
        end else begin
            if (r_state == S_FETCH && imem_ack) r_ir <= imem_rdata;
            if (r_state == S_DECODE) begin
                r_a <= (w_rs == 3'd0) ? '0 : r_rf[w_rs];
                r_b <= (w_rt == 3'd0) ? '0 : r_rf[w_rt];
            end
            if (r_state == S_EXEC) r_alu <= w_alu;
            if (r_state == S_MEM && dmem_ack && w_op == OP_LW) r_mdr <= dmem_rdata;
        end
    end

    // Register file write-back; R0 stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_state == S_WB && w_dest != 3'd0) begin
            r_rf[w_dest] <= w_wb_dat;
        end
    end

`ifdef CPU_MC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt, r_instret_cnt;

    // Cycle counter stops in HALT; instret counts each retirement strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign cycle_cnt       = '0;
    assign instret_cnt     = '0;
`endif

endmodule

// File: tb/tb_cpu_mc_core.sv
// Scoreboard bench: expected fetch/data transactions are queued per program, monitors pop on each ack.
// Latency: fetch gaps check the per-instruction cycle counts.
// Backpressure: memory models insert configurable wait states before ack.
module tb_cpu_mc_core;

    logic        clk;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [18:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [7:0]  pc;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] cycle_cnt, instret_cnt;

    cpu_mc_core dut (
        .clk         (clk),
        .reset       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .pc          (pc),
        .halted      (halted),
        .err         (err),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; int gap; } fexp_t;
    typedef struct { logic [7:0] addr; logic we; logic [31:0] dat; int len; } dexp_t;

    fexp_t       f_q[$];
    dexp_t       d_q[$];
    logic [18:0] imem [256];
    logic [31:0] dmem [256];
    int          i_delay = 0;
    int          d_delay = 0;
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;

    localparam logic [18:0] HALT_W = {5'd31, 14'd0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [18:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {5'd0, 3'(rs), 3'(rt), 3'(rd), 5'(fn)};
    endfunction

    function automatic logic [18:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {5'(op), 3'(rs), 3'(rt), 8'(imm)};
    endfunction

    task automatic exp_f(input int addr, input int gap);
        fexp_t e;
        e.addr = 8'(addr);
        e.gap  = gap;
        f_q.push_back(e);
    endtask

    task automatic exp_d(input int addr, input logic we, input logic [31:0] dat, input int len);
        dexp_t e;
        e.addr = 8'(addr);
        e.we   = we;
        e.dat  = dat;
        e.len  = len;
        d_q.push_back(e);
    endtask

    function automatic logic [31:0] perf(input int v);
`ifdef CPU_MC_PERF_CNT_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Instruction memory model with i_delay wait states.
    initial begin
        int iw;
        iw = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req) begin
                if (iw >= i_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem[imem_addr];
                    iw = 0;
                end else begin
                    iw++;
                end
            end else begin
                iw = 0;
            end
        end
    end

    // Data memory model with d_delay wait states.
    initial begin
        int dw;
        dw = 0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (dw >= d_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = dmem[dmem_addr];
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    dw = 0;
                end else begin
                    dw++;
                end
            end else begin
                dw = 0;
            end
        end
    end

    // Monitor: pops expected fetch/data transactions on every acknowledged request.
    initial begin
        int last_f, d_len;
        fexp_t fe;
        dexp_t de;
        last_f = 0;
        d_len  = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                d_len = 0;
            end else begin
                if (dmem_req) d_len++;
                if (imem_req && imem_ack) begin
                    if (f_q.size() == 0) begin
                        chk("fetch_unexpected", {24'd0, imem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        fe = f_q.pop_front();
                        chk("fetch_addr", {24'd0, imem_addr}, {24'd0, fe.addr});
                        if (fe.gap > 0) chk("fetch_gap", 32'(cyc - last_f), 32'(fe.gap));
                    end
                    last_f = cyc;
                end
                if (dmem_req && dmem_ack) begin
                    if (d_q.size() == 0) begin
                        chk("dmem_unexpected", {24'd0, dmem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        de = d_q.pop_front();
                        chk("dmem_addr", {24'd0, dmem_addr}, {24'd0, de.addr});
                        chk("dmem_we", {31'd0, dmem_we}, {31'd0, de.we});
                        if (de.we) chk("dmem_wdata", dmem_wdata, de.dat);
                        chk("dmem_req_len", 32'(d_len), 32'(de.len));
                    end
                    d_len = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            imem[i] = HALT_W;
            dmem[i] = '0;
        end
        f_q.delete();
        d_q.delete();
    endtask

    task automatic run(input string nm, input int e_err, input int e_pc, input int e_ret, input int e_cyc);
        int n;
        @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!halted) chk({nm, "_timeout"}, 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
        chk({nm, "_err"}, {30'd0, err}, 32'(e_err));
        chk({nm, "_imem_req_idle"}, {31'd0, imem_req}, 32'd0);
        if (e_pc >= 0) chk({nm, "_pc"}, {24'd0, pc}, 32'(e_pc));
        chk({nm, "_instret"}, instret_cnt, perf(e_ret));
        chk({nm, "_cycles"}, cycle_cnt, perf(e_cyc));
        chk({nm, "_fetch_left"}, 32'(f_q.size()), 32'd0);
        chk({nm, "_dmem_left"}, 32'(d_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {30'd0, dmem_req, dmem_we}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_halted_err", {29'd0, halted, err}, 32'd0);
        chk("rst_counters", cycle_cnt | instret_cnt, 32'd0);

        // ADDI/ADDI/ADD then HALT.
        do_reset();
        imem[0] = enc_i(1, 0, 1, 5);
        imem[1] = enc_i(1, 0, 2, 7);
        imem[2] = enc_r(1, 2, 3, 0);
        exp_f(0, 0); exp_f(1, 4); exp_f(2, 4); exp_f(3, 4);
        run("alu", 0, 3, 3, 14);

        // Store/load through 3-wait-state data memory.
        do_reset();
        d_delay = 3;
        imem[0] = enc_i(1, 0, 1, 5);
        imem[1] = enc_i(1, 0, 2, 7);
        imem[2] = enc_r(1, 2, 3, 0);
        imem[3] = enc_i(3, 0, 3, 8'h10);
        imem[4] = enc_i(2, 1, 4, 8'h0B);
        imem[5] = enc_i(3, 0, 4, 8'h11);
        exp_f(0, 0); exp_f(1, 4); exp_f(2, 4); exp_f(3, 4); exp_f(4, 7); exp_f(5, 8); exp_f(6, 7);
        exp_d(8'h10, 1'b1, 32'd12, 4); exp_d(8'h10, 1'b0, 32'd0, 4); exp_d(8'h11, 1'b1, 32'd12, 4);
        run("mem", 0, 6, 6, 36);
        d_delay = 0;

        // Branch taken/not taken and jump.
        do_reset();
        imem[0]     = enc_i(1, 0, 1, 3);
        imem[1]     = enc_i(4, 1, 1, 8'h20);
        imem[8'h20] = enc_i(5, 1, 1, 8'h40);
        imem[8'h21] = enc_i(4, 1, 0, 8'h40);
        imem[8'h22] = enc_i(5, 1, 0, 8'h30);
        imem[8'h30] = enc_i(6, 0, 0, 8'h50);
        exp_f(0, 0); exp_f(1, 4); exp_f(8'h20, 3); exp_f(8'h21, 3); exp_f(8'h22, 3); exp_f(8'h30, 3); exp_f(8'h50, 3);
        run("branch", 0, 8'h50, 6, 21);

        // Nested CALLs to full depth, RETs in LIFO order, then RET on empty.
        do_reset();
        for (int k = 0; k < 8; k++) imem[k*16] = enc_i(7, 0, 0, (k+1)*16);
        imem[8'h80] = enc_i(8, 0, 0, 0);
        for (int k = 0; k < 8; k++) imem[k*16+1] = enc_i(8, 0, 0, 0);
        exp_f(0, 0);
        for (int k = 1; k <= 8; k++) exp_f(k*16, 3);
        for (int k = 7; k >= 0; k--) exp_f(k*16+1, 3);
        run("ret_lifo", 3, -1, 16, 51);

        // Extra CALL with the stack full.
        do_reset();
        for (int k = 0; k < 8; k++) imem[k*16] = enc_i(7, 0, 0, (k+1)*16);
        imem[8'h80] = enc_i(7, 0, 0, 8'h90);
        exp_f(0, 0);
        for (int k = 1; k <= 8; k++) exp_f(k*16, 3);
        run("call_ovf", 2, 8'h80, 8, 27);

        // Undefined opcode 01010.
        do_reset();
        imem[0] = {5'b01010, 14'd0};
        exp_f(0, 0);
        run("bad_op", 1, 0, 0, 2);

        // Undefined funct.
        do_reset();
        imem[0] = enc_i(1, 0, 1, 1);
        imem[1] = enc_r(1, 1, 2, 9);
        exp_f(0, 0); exp_f(1, 4);
        run("bad_funct", 1, 1, 1, 6);

        // Reset asserted while a fetch is waiting for ack.
        do_reset();
        i_delay = 6;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("midfetch_req_before", {31'd0, imem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midfetch_req_drop", {31'd0, imem_req}, 32'd0);
        chk("midfetch_pc", {24'd0, pc}, 32'd0);
        repeat (8) @(negedge clk);
        #1;
        chk("midfetch_req_held", {31'd0, imem_req}, 32'd0);
        i_delay = 0;

        // PC wrap at 0xFF, ADD wrap, SLT, SRL, R0 write discarded.
        do_reset();
        imem[0]     = enc_i(5, 5, 0, 8'h20);
        imem[1]     = enc_i(1, 0, 5, 1);
        imem[2]     = enc_r(0, 5, 1, 1);
        imem[3]     = enc_i(6, 0, 0, 8'hFF);
        imem[8'hFF] = enc_r(1, 5, 3, 0);
        imem[8'h20] = enc_i(3, 0, 3, 5);
        imem[8'h21] = enc_r(1, 5, 4, 5);
        imem[8'h22] = enc_i(3, 0, 4, 6);
        imem[8'h23] = enc_r(1, 5, 6, 7);
        imem[8'h24] = enc_i(3, 0, 6, 7);
        imem[8'h25] = enc_i(1, 0, 0, 9);
        imem[8'h26] = enc_i(3, 0, 0, 8);
        exp_f(0, 0); exp_f(1, 3); exp_f(2, 4); exp_f(3, 4); exp_f(8'hFF, 3); exp_f(0, 4);
        exp_f(8'h20, 3);
        for (int a = 8'h21; a <= 8'h27; a++) exp_f(a, 4);
        exp_d(5, 1'b1, 32'd0, 1); exp_d(6, 1'b1, 32'd1, 1);
        exp_d(7, 1'b1, 32'h7FFF_FFFF, 1); exp_d(8, 1'b1, 32'd0, 1);
        run("wrap", 0, 8'h27, 13, 51);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
